// File: rtl/fdivsqrt_otfc_seq_pkg.sv
// Shared definitions for the divsqrt on-the-fly converter.
//   otfc_state_t : converter FSM states
//   log2r/dig_max/dig_min : radix-derived digit constants
//   pos0/nsteps  : first digit position and digit count for a given mode
package fdivsqrt_otfc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } otfc_state_t;

    function automatic int log2r(input int radix);
        return (radix == 4) ? 2 : 1;
    endfunction

    // Legal digit range is -A..+A with A = RADIX/2.
    function automatic int dig_max(input int radix);
        return radix / 2;
    endfunction

    function automatic int dig_min(input int radix);
        return -(radix / 2);
    endfunction

    // Square root starts one digit lower because U already holds the 1.0 bit.
    function automatic int pos0(input int divb, input int radix, input logic sqrt);
        return sqrt ? (divb + 1 - 2 * log2r(radix)) : (divb + 1 - log2r(radix));
    endfunction

    function automatic int nsteps(input int divb, input int radix, input logic sqrt);
        return pos0(divb, radix, sqrt) / log2r(radix) + 1;
    endfunction

endpackage

// File: rtl/fdivsqrt_otfc_step.sv
// Combinational U/UM next-value logic for one signed digit.
//   q       : digit, already saturated to -A..+A
//   k       : one-hot weight of the digit position (1 << pos)
//   u, um   : current U and UM
//   u_next, um_next : values after absorbing q
module fdivsqrt_otfc_step #(
    parameter int DIVb  = 64,
    parameter int RADIX = 2,
    parameter int DW    = 3
) (
    input  logic signed [DW-1:0] q,
    input  logic [DIVb:0]        k,
    input  logic [DIVb:0]        u,
    input  logic [DIVb:0]        um,
    output logic [DIVb:0]        u_next,
    output logic [DIVb:0]        um_next
);

    // Field value times k; the field is at most two bits wide, so a shift-or
    // replaces the multiply. Bits shifted past DIVb are dropped.
    function automatic logic [DIVb:0] scale(input logic [1:0] f, input logic [DIVb:0] kk);
        return (f[0] ? kk : '0) | (f[1] ? (kk << 1) : '0);
    endfunction

    int qi;
    int mi;

    always_comb begin
        qi      = int'(q);
        mi      = (qi < 0) ? -qi : qi;
        u_next  = u;
        um_next = um;
        if (qi > 0) begin
            u_next  = u | scale(2'(qi), k);
            um_next = u | scale(2'(qi - 1), k);
        end else if (qi == 0) begin
            u_next  = u;
            um_next = um | scale(2'(RADIX - 1), k);
        end else begin
            u_next  = um | scale(2'(RADIX - mi), k);
            um_next = um | scale(2'(RADIX - mi - 1), k);
        end
    end

endmodule

// File: rtl/fdivsqrt_otfc_seq.sv
// Sequential on-the-fly converter: folds one signed radix-2/4 digit per
// handshake into registered U and UM and pulses done after the last digit.
//   clk, reset (async, active low)
//   start/sqrtmode : begin a conversion (any state), sqrtmode sampled with it
//   flush          : abort the running conversion, results frozen
//   digit_valid/digit : digit handshake, accepted only while busy
//   busy, done, digit_err : status; U, UM : results; fsm_state : FSM state
// Handshake: a digit transfers on a rising edge where busy=1 and
// digit_valid=1 and neither start nor flush is asserted; there is no
// backpressure beyond busy, and the producer may stall indefinitely.
module fdivsqrt_otfc_seq
    import fdivsqrt_otfc_seq_pkg::*;
#(
    parameter int DIVb  = 64,
    parameter int RADIX = 2,
    parameter int DW    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sqrtmode,
    input  logic                 flush,
    input  logic                 digit_valid,
    input  logic signed [DW-1:0] digit,
    output logic                 busy,
    output logic                 done,
    output logic                 digit_err,
    output logic [DIVb:0]        U,
    output logic [DIVb:0]        UM,
    output otfc_state_t          fsm_state
);

    localparam int LOG2R = log2r(RADIX);
    localparam int A     = dig_max(RADIX);
    localparam int AMIN  = dig_min(RADIX);
    localparam int PW    = $clog2(DIVb + 2);

    localparam logic [PW-1:0] POS0_DIV  = PW'(pos0(DIVb, RADIX, 1'b0));
    localparam logic [PW-1:0] POS0_SQRT = PW'(pos0(DIVb, RADIX, 1'b1));
    localparam logic [PW-1:0] LAST_DIV  = PW'(nsteps(DIVb, RADIX, 1'b0) - 1);
    localparam logic [PW-1:0] LAST_SQRT = PW'(nsteps(DIVb, RADIX, 1'b1) - 1);

    otfc_state_t          state, state_n;
    logic [PW-1:0]        pos, step;
    logic                 sqrt_r;
    logic                 err_r;
    logic [DIVb:0]        u_r, um_r, u_nx, um_nx, k;
    logic                 accept, last, illegal;
    logic signed [DW-1:0] q_sat;

    // start beats flush and digit_valid; flush beats digit_valid.
    assign accept = (state == RUN) && digit_valid && !start && !flush;
    assign last   = (step == (sqrt_r ? LAST_SQRT : LAST_DIV));
    assign k      = {{DIVb{1'b0}}, 1'b1} << pos;

    // Out-of-range digits are clamped to +-A and flagged.
    always_comb begin
        q_sat   = digit;
        illegal = 1'b0;
        if (int'(digit) > A) begin
            q_sat   = DW'(A);
            illegal = 1'b1;
        end else if (int'(digit) < AMIN) begin
            q_sat   = DW'(AMIN);
            illegal = 1'b1;
        end
    end

    fdivsqrt_otfc_step #(
        .DIVb (DIVb),
        .RADIX(RADIX),
        .DW   (DW)
    ) u_step (
        .q      (q_sat),
        .k      (k),
        .u      (u_r),
        .um     (um_r),
        .u_next (u_nx),
        .um_next(um_nx)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = IDLE;
            RUN: begin
                if (flush)
                    state_n = IDLE;
                else if (accept && last)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (start)
            state_n = RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_r    <= '0;
            um_r   <= '0;
            pos    <= '0;
            step   <= '0;
            sqrt_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (start) begin
            u_r    <= sqrtmode ? ({{DIVb{1'b0}}, 1'b1} << DIVb) : '0;
            um_r   <= '0;
            pos    <= sqrtmode ? POS0_SQRT : POS0_DIV;
            step   <= '0;
            sqrt_r <= sqrtmode;
            err_r  <= 1'b0;
        end else if (accept) begin
            u_r  <= u_nx;
            um_r <= um_nx;
            pos  <= pos - PW'(LOG2R);
            step <= step + PW'(1);
            if (illegal)
                err_r <= 1'b1;
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign digit_err = err_r;
    assign U         = u_r;
    assign UM        = um_r;
    assign fsm_state = state;

endmodule

// File: tb/tb_fdivsqrt_otfc_seq.sv
module tb_fdivsqrt_otfc_seq;
    import fdivsqrt_otfc_seq_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, sqrtmode = 1'b0, flush = 1'b0, digit_valid = 1'b0;
    logic signed [2:0] digit = '0;

    logic busy2, done2, err2, busy4, done4, err4;
    logic [8:0] U2, UM2, U4, UM4;
    otfc_state_t st2, st4;

    int total = 0;
    int passed = 0;

    fdivsqrt_otfc_seq #(.DIVb(8), .RADIX(2), .DW(3)) dut2 (
        .clk(clk), .reset(reset), .start(start), .sqrtmode(sqrtmode), .flush(flush),
        .digit_valid(digit_valid), .digit(digit), .busy(busy2), .done(done2),
        .digit_err(err2), .U(U2), .UM(UM2), .fsm_state(st2)
    );

    fdivsqrt_otfc_seq #(.DIVb(8), .RADIX(4), .DW(3)) dut4 (
        .clk(clk), .reset(reset), .start(start), .sqrtmode(sqrtmode), .flush(flush),
        .digit_valid(digit_valid), .digit(digit), .busy(busy4), .done(done4),
        .digit_err(err4), .U(U4), .UM(UM4), .fsm_state(st4)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic sq);
        start = 1'b1;
        sqrtmode = sq;
        tick();
        start = 1'b0;
    endtask

    task automatic send_digit(input int d);
        digit_valid = 1'b1;
        digit = 3'(d);
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total++; if ({busy2, done2, err2, U2, UM2} !== 21'd0) $display("FAIL reset_r2: got %b/%b/%b %h %h want all 0", busy2, done2, err2, U2, UM2); else passed++;
        total++; if ({busy4, done4, err4, U4, UM4} !== 21'd0) $display("FAIL reset_r4: got %b/%b/%b %h %h want all 0", busy4, done4, err4, U4, UM4); else passed++;
        total++; if (st2 !== IDLE) $display("FAIL reset_state: got %0d want %0d", st2, IDLE); else passed++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_div_r2_basic;
        do_start(1'b0);
        total++; if (busy2 !== 1'b1) $display("FAIL r2_busy_after_start: got %b want 1", busy2); else passed++;
        send_digit(1);
        send_digit(1);
        for (int i = 0; i < 6; i++) send_digit(0);
        total++; if (done2 !== 1'b0 || busy2 !== 1'b1) $display("FAIL r2_not_done_at_8: got done=%b busy=%b want 0/1", done2, busy2); else passed++;
        send_digit(0);
        total++; if (done2 !== 1'b1 || busy2 !== 1'b0) $display("FAIL r2_done_at_9: got done=%b busy=%b want 1/0", done2, busy2); else passed++;
        total++; if (U2 !== 9'h180) $display("FAIL r2_basic_u: got %h want 180", U2); else passed++;
        total++; if (UM2 !== 9'h17F) $display("FAIL r2_basic_um: got %h want 17f", UM2); else passed++;
        tick();
        total++; if (done2 !== 1'b0) $display("FAIL r2_done_one_cycle: got %b want 0", done2); else passed++;
        total++; if (U2 !== 9'h180) $display("FAIL r2_hold_idle: got %h want 180", U2); else passed++;
    endtask

    task automatic test_div_r2_neg;
        do_start(1'b0);
        send_digit(1);
        send_digit(-1);
        for (int i = 0; i < 7; i++) send_digit(0);
        total++; if (U2 !== 9'h080) $display("FAIL r2_neg_u: got %h want 080", U2); else passed++;
        total++; if (UM2 !== 9'h07F) $display("FAIL r2_neg_um: got %h want 07f", UM2); else passed++;
        total++; if (err2 !== 1'b0) $display("FAIL r2_neg_err: got %b want 0", err2); else passed++;
        tick();
    endtask

    task automatic test_div_r4;
        int dcnt;
        int ds[4];
        ds = '{2, -1, 0, 0};
        dcnt = 0;
        do_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_digit(ds[i]);
            if (done4) dcnt++;
        end
        total++; if (done4 !== 1'b1) $display("FAIL r4_done_at_4: got %b want 1", done4); else passed++;
        total++; if (U4 !== 9'h0E0) $display("FAIL r4_u: got %h want 0e0", U4); else passed++;
        total++; if (UM4 !== 9'h0DE) $display("FAIL r4_um: got %h want 0de", UM4); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done4) dcnt++;
        end
        total++; if (dcnt !== 1) $display("FAIL r4_done_count: got %0d want 1", dcnt); else passed++;
    endtask

    task automatic test_illegal_digit;
        do_start(1'b0);
        send_digit(3);
        total++; if (err4 !== 1'b1) $display("FAIL r4_err_set: got %b want 1", err4); else passed++;
        send_digit(-1);
        send_digit(0);
        send_digit(0);
        total++; if (U4 !== 9'h0E0 || UM4 !== 9'h0DE) $display("FAIL r4_sat_result: got %h/%h want 0e0/0de", U4, UM4); else passed++;
        tick();
        tick();
        total++; if (err4 !== 1'b1) $display("FAIL r4_err_sticky: got %b want 1", err4); else passed++;
        do_start(1'b0);
        total++; if (err4 !== 1'b0) $display("FAIL r4_err_cleared: got %b want 0", err4); else passed++;
    endtask

    task automatic test_flush;
        int dcnt;
        dcnt = 0;
        do_start(1'b0);
        send_digit(1);
        send_digit(1);
        send_digit(1);
        total++; if (U2 !== 9'h1C0 || UM2 !== 9'h180) $display("FAIL flush_pre: got %h/%h want 1c0/180", U2, UM2); else passed++;
        flush = 1'b1;
        digit_valid = 1'b1;
        digit = 3'sd1;
        tick();
        flush = 1'b0;
        total++; if (busy2 !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy2); else passed++;
        for (int i = 0; i < 10; i++) begin
            if (done2) dcnt++;
            tick();
        end
        digit_valid = 1'b0;
        total++; if (dcnt !== 0) $display("FAIL flush_no_done: got %0d pulses want 0", dcnt); else passed++;
        total++; if (U2 !== 9'h1C0 || UM2 !== 9'h180) $display("FAIL flush_held: got %h/%h want 1c0/180", U2, UM2); else passed++;
    endtask

    task automatic test_reset_midrun;
        do_start(1'b0);
        send_digit(1);
        total++; if (U2 !== 9'h100) $display("FAIL rst_mid_pre: got %h want 100", U2); else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++; if ({busy2, done2, err2, U2, UM2} !== 21'd0) $display("FAIL rst_mid_async: got %b/%b/%b %h %h want all 0", busy2, done2, err2, U2, UM2); else passed++;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_start_collision;
        do_start(1'b0);
        send_digit(1);
        send_digit(1);
        start = 1'b1;
        sqrtmode = 1'b0;
        digit_valid = 1'b1;
        digit = 3'sd1;
        tick();
        start = 1'b0;
        digit_valid = 1'b0;
        total++; if (U2 !== 9'h000 || busy2 !== 1'b1) $display("FAIL coll_reinit: got U=%h busy=%b want 000/1", U2, busy2); else passed++;
        send_digit(1);
        send_digit(1);
        for (int i = 0; i < 6; i++) send_digit(0);
        total++; if (done2 !== 1'b0) $display("FAIL coll_step0: got done=%b after 8 digits want 0", done2); else passed++;
        send_digit(0);
        total++; if (done2 !== 1'b1 || U2 !== 9'h180 || UM2 !== 9'h17F) $display("FAIL coll_result: got done=%b %h/%h want 1 180/17f", done2, U2, UM2); else passed++;
    endtask

    task automatic test_idle_digits;
        tick();
        digit_valid = 1'b1;
        digit = 3'sd1;
        for (int i = 0; i < 3; i++) tick();
        digit_valid = 1'b0;
        total++; if (U2 !== 9'h180 || UM2 !== 9'h17F || busy2 !== 1'b0) $display("FAIL idle_ignore: got %h/%h busy=%b want 180/17f 0", U2, UM2, busy2); else passed++;
    endtask

    task automatic test_sqrt_r2;
        do_start(1'b1);
        total++; if (U2 !== 9'h100 || UM2 !== 9'h000) $display("FAIL sqrt_init: got %h/%h want 100/000", U2, UM2); else passed++;
        for (int i = 0; i < 7; i++) send_digit(0);
        total++; if (done2 !== 1'b0) $display("FAIL sqrt_not_done_7: got %b want 0", done2); else passed++;
        send_digit(0);
        total++; if (done2 !== 1'b1 || U2 !== 9'h100 || UM2 !== 9'h0FF) $display("FAIL sqrt_result: got done=%b %h/%h want 1 100/0ff", done2, U2, UM2); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_div_r2_basic();
        test_div_r2_neg();
        test_div_r4();
        test_illegal_digit();
        test_flush();
        test_reset_midrun();
        test_start_collision();
        test_idle_digits();
        test_sqrt_r2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
